// File: rtl/ultrasonic_echo_responder_pkg.sv
// Shared definitions for the ultrasonic echo responder: FSM state encoding and default timing.
package ultrasonic_echo_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG    = 3'd1,
    ST_DELAY   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  localparam int unsigned DEF_CNT_W             = 32;
  localparam int unsigned DEF_MIN_TRIG_CYCLES   = 500;
  localparam int unsigned DEF_ECHO_DELAY_CYCLES = 22500;
  localparam int unsigned DEF_TIMEOUT_CYCLES    = 1900000;
  localparam int unsigned DEF_HOLDOFF_CYCLES    = 3000000;
  localparam int unsigned PING_W                = 16;

endpackage

// File: rtl/ultrasonic_echo_responder_sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous inputs such as the trigger pin.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 style responder: answers each valid trigger pulse with one echo pulse
// whose width in clk cycles encodes the programmed distance.
module ultrasonic_echo_responder
  import ultrasonic_echo_responder_pkg::*;
#(
  parameter int unsigned CNT_W             = DEF_CNT_W,
  parameter int unsigned MIN_TRIG_CYCLES   = DEF_MIN_TRIG_CYCLES,
  parameter int unsigned ECHO_DELAY_CYCLES = DEF_ECHO_DELAY_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES    = DEF_HOLDOFF_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_trig_in,
  input  logic [CNT_W-1:0]  i_echo_len,
  output logic              o_echo_out,
  output logic              o_busy,
  output logic              o_trig_short,
  output logic              o_echo_done,
  output logic [PING_W-1:0] o_ping_count
);

  localparam logic [CNT_W-1:0] L_MIN     = CNT_W'(MIN_TRIG_CYCLES);
  localparam logic [CNT_W-1:0] L_DELAY   = CNT_W'(ECHO_DELAY_CYCLES);
  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] L_HOLDOFF = CNT_W'(HOLDOFF_CYCLES);

  logic              w_trig_sync;
  logic              r_trig_d;
  logic              w_rise;
  logic              w_fall;
  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_trig_cnt;
  logic [CNT_W-1:0]  w_trig_cnt_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  w_len_next;
  logic [CNT_W-1:0]  w_len_clamped;
  logic              r_echo_out;
  logic              r_busy;
  logic              r_trig_short;
  logic              r_echo_done;
  logic [PING_W-1:0] r_ping_count;
  logic              w_echo_out_next;
  logic              w_busy_next;
  logic              w_trig_short_next;
  logic              w_echo_done_next;
  logic [PING_W-1:0] w_ping_count_next;

  sync_2ff u_trig_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_trig_in),
    .o_q     (w_trig_sync)
  );

  assign w_rise        = w_trig_sync & ~r_trig_d;
  assign w_fall        = ~w_trig_sync & r_trig_d;
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_len_clamped = ((i_echo_len == '0) || (i_echo_len > L_TIMEOUT)) ? L_TIMEOUT : i_echo_len;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trig_d     <= 1'b0;
      r_state      <= ST_IDLE;
      r_trig_cnt   <= '0;
      r_cnt        <= '0;
      r_len        <= '0;
      r_echo_out   <= 1'b0;
      r_busy       <= 1'b0;
      r_trig_short <= 1'b0;
      r_echo_done  <= 1'b0;
      r_ping_count <= '0;
    end else begin
      r_trig_d     <= w_trig_sync;
      r_state      <= w_state_next;
      r_trig_cnt   <= w_trig_cnt_next;
      r_cnt        <= w_cnt_next;
      r_len        <= w_len_next;
      r_echo_out   <= w_echo_out_next;
      r_busy       <= w_busy_next;
      r_trig_short <= w_trig_short_next;
      r_echo_done  <= w_echo_done_next;
      r_ping_count <= w_ping_count_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_trig_cnt_next = r_trig_cnt;
    w_cnt_next      = r_cnt;
    w_len_next      = r_len;
    case (r_state)
      ST_IDLE: begin
        if (w_rise && i_enable) begin
          w_state_next    = ST_TRIG;
          w_trig_cnt_next = CNT_W'(1);
        end
      end
      ST_TRIG: begin
        if (w_fall) begin
          if (r_trig_cnt >= L_MIN) begin
            w_state_next = ST_DELAY;
            w_len_next   = w_len_clamped;
            // The fall-detect cycle is the first delay cycle, so echo rises DELAY cycles after the synced fall.
            w_cnt_next   = CNT_W'(1);
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (w_trig_sync && (r_trig_cnt != '1)) begin
          w_trig_cnt_next = r_trig_cnt + 1'b1;
        end
      end
      ST_DELAY: begin
        w_cnt_next = w_cnt_inc;
        if (w_cnt_inc >= L_DELAY) begin
          w_state_next = ST_ECHO;
          w_cnt_next   = '0;
        end
      end
      ST_ECHO: begin
        w_cnt_next = w_cnt_inc;
        if (w_cnt_inc >= r_len) begin
          w_state_next = ST_HOLDOFF;
          w_cnt_next   = '0;
        end
      end
      ST_HOLDOFF: begin
        w_cnt_next = w_cnt_inc;
        if (w_cnt_inc >= L_HOLDOFF) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state and registered, so they are glitch-free.
  always_comb begin
    w_echo_out_next   = (w_state_next == ST_ECHO);
    w_busy_next       = (w_state_next != ST_IDLE);
    w_trig_short_next = (r_state == ST_TRIG) && (w_state_next == ST_IDLE);
    w_echo_done_next  = (r_state == ST_ECHO) && (w_state_next == ST_HOLDOFF);
    w_ping_count_next = r_ping_count + PING_W'(w_echo_done_next);
  end

  assign o_echo_out   = r_echo_out;
  assign o_busy       = r_busy;
  assign o_trig_short = r_trig_short;
  assign o_echo_done  = r_echo_done;
  assign o_ping_count = r_ping_count;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Self-checking bench: directed and random pings compared against an event-time reference model.
module tb_ultrasonic_echo_responder;

  localparam int MIN_T = 10;
  localparam int DLY   = 20;
  localparam int TMO   = 1000;
  localparam int HOLD  = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        trig;
  logic [31:0] echo_len;
  logic        echo_out;
  logic        busy;
  logic        trig_short;
  logic        echo_done;
  logic [15:0] ping_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int idle_from = 0;
  int exp_ping  = 0;
  logic prev_echo = 1'b0;

  int obs_rise[$];
  int obs_fall[$];
  int obs_done[$];
  int obs_short[$];
  int exp_rise[$];
  int exp_fall[$];
  int exp_short[$];

  ultrasonic_echo_responder #(
    .CNT_W             (32),
    .MIN_TRIG_CYCLES   (MIN_T),
    .ECHO_DELAY_CYCLES (DLY),
    .TIMEOUT_CYCLES    (TMO),
    .HOLDOFF_CYCLES    (HOLD)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_trig_in    (trig),
    .i_echo_len   (echo_len),
    .o_echo_out   (echo_out),
    .o_busy       (busy),
    .o_trig_short (trig_short),
    .o_echo_done  (echo_done),
    .o_ping_count (ping_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample 1 time unit after the rising edge and log output events by cycle number.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (echo_out && !prev_echo) obs_rise.push_back(cyc);
    if (!echo_out && prev_echo) obs_fall.push_back(cyc);
    if (echo_done) obs_done.push_back(cyc);
    if (trig_short) obs_short.push_back(cyc);
    prev_echo = echo_out;
  endtask

  function automatic int clamp_len(input int unsigned len);
    return ((len == 0) || (len > TMO)) ? TMO : int'(len);
  endfunction

  // Reference: pin rises after cycle 'rise' and stays high n cycles; synchroniser lag is 2 cycles.
  task automatic model_trigger(input int rise, input int n, input int unsigned len, input bit en);
    int p;
    int r;
    int f;
    if (!en || (rise + 2 < idle_from)) return;
    p = rise + n;
    if (n < MIN_T) begin
      exp_short.push_back(p + 3);
      idle_from = p + 3;
      return;
    end
    r = p + 2 + ((DLY > 2) ? DLY : 2);
    f = r + clamp_len(len);
    exp_rise.push_back(r);
    exp_fall.push_back(f);
    idle_from = f + ((HOLD > 1) ? HOLD : 1);
    exp_ping = (exp_ping + 1) & 16'hFFFF;
  endtask

  task automatic pulse(input int n, input int unsigned len, input bit en);
    echo_len = len;
    enable   = en;
    trig     = 1'b1;
    model_trigger(cyc, n, len, en);
    repeat (n) tick();
    trig = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
    while (cyc < idle_from + 4) tick();
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nrise"}, obs_rise.size(), exp_rise.size());
    chk({tag, "_nfall"}, obs_fall.size(), exp_fall.size());
    chk({tag, "_ndone"}, obs_done.size(), exp_fall.size());
    chk({tag, "_nshort"}, obs_short.size(), exp_short.size());
    for (int i = 0; i < exp_rise.size() && i < obs_rise.size(); i++)
      chk($sformatf("%s_rise%0d", tag, i), obs_rise[i], exp_rise[i]);
    for (int i = 0; i < exp_fall.size() && i < obs_fall.size(); i++)
      chk($sformatf("%s_fall%0d", tag, i), obs_fall[i], exp_fall[i]);
    for (int i = 0; i < exp_fall.size() && i < obs_done.size(); i++)
      chk($sformatf("%s_done%0d", tag, i), obs_done[i], exp_fall[i]);
    for (int i = 0; i < exp_short.size() && i < obs_short.size(); i++)
      chk($sformatf("%s_short%0d", tag, i), obs_short[i], exp_short[i]);
    chk({tag, "_ping"}, ping_count, exp_ping);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_echo_end"}, echo_out, 0);
    obs_rise.delete(); obs_fall.delete(); obs_done.delete(); obs_short.delete();
    exp_rise.delete(); exp_fall.delete(); exp_short.delete();
  endtask

  initial begin
    int f;
    int n;
    int sel;
    int unsigned len;

    rst_n = 1'b1; enable = 1'b0; trig = 1'b0; echo_len = '0;
    #2 rst_n = 1'b0;
    #2;
    chk("reset_echo", echo_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_short", trig_short, 0);
    chk("reset_done", echo_done, 0);
    chk("reset_ping", ping_count, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    idle_from = cyc;

    // Nominal ping
    pulse(12, 300, 1'b1);
    repeat (3) tick();
    chk("nominal_busy", busy, 1);
    drain();
    compare("nominal");

    // Short trigger, then the exact minimum width
    pulse(9, 300, 1'b1);
    drain();
    compare("short");
    pulse(MIN_T, 40, 1'b1);
    drain();
    compare("min_width");

    // Clamping of zero / oversize / exact-timeout lengths
    pulse(12, 0, 1'b1);
    drain();
    compare("clamp_zero");
    pulse(12, 5000, 1'b1);
    drain();
    compare("clamp_big");
    pulse(12, TMO, 1'b1);
    drain();
    compare("clamp_exact");

    // Holdoff: retrigger 10 cycles after echo fall is dropped, 60 cycles after is answered
    pulse(12, 300, 1'b1);
    f = exp_fall[$];
    while (cyc < f + 10) tick();
    pulse(12, 300, 1'b1);
    while (cyc < f + 60) tick();
    pulse(12, 200, 1'b1);
    drain();
    compare("holdoff");

    // Enable low in IDLE; enable dropped during DELAY; echo_len changed during ECHO
    pulse(12, 300, 1'b0);
    drain();
    compare("enable_off");
    pulse(12, 300, 1'b1);
    repeat (5) tick();
    enable = 1'b0;
    while (cyc < exp_rise[$] + 5) tick();
    echo_len = 7;
    drain();
    compare("enable_drop_len_change");
    enable = 1'b1;

    // Asynchronous reset in the middle of an echo
    pulse(12, 300, 1'b1);
    while (cyc < exp_rise[$] + 5) tick();
    chk("pre_reset_echo", echo_out, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_echo", echo_out, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_ping", ping_count, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    obs_rise.delete(); obs_fall.delete(); obs_done.delete(); obs_short.delete();
    exp_rise.delete(); exp_fall.delete(); exp_short.delete();
    exp_ping = 0;
    prev_echo = echo_out;
    tick();
    idle_from = cyc;
    pulse(12, 300, 1'b1);
    drain();
    compare("after_reset");

    // Random widths and lengths, including short triggers and clamp cases
    for (int i = 0; i < 8; i++) begin
      n   = $urandom_range(MIN_T + 10, MIN_T - 4);
      sel = $urandom_range(3, 0);
      len = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(5000, TMO + 1) : $urandom_range(900, 1);
      repeat ($urandom_range(30, 3)) tick();
      pulse(n, len, 1'b1);
      drain();
      compare($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
